// File: rtl/write_engine_pkg.sv
// Shared types and constants for the write engine.
// WRITE_ENGINE_BYTE_ADDR_EN selects byte addressing (step DATA_WIDTH/8) instead of word addressing (step 1).
package write_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } we_state_t;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;

`ifdef WRITE_ENGINE_BYTE_ADDR_EN
    localparam bit BYTE_ADDR = 1'b1;
`else
    localparam bit BYTE_ADDR = 1'b0;
`endif

    function automatic int beat_addr_incr(input int data_width);
        return BYTE_ADDR ? (data_width / 8) : 1;
    endfunction

    localparam int ADDR_INCR = beat_addr_incr(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/write_engine_beat_counter.sv
// 32-bit beat counter with synchronous clear; stops counting once it reaches the limit.
module write_beat_counter (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < limit)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/write_engine.sv
// Write engine: pulls beats from a valid/ready source and issues strobed writes to a RAM-like peripheral.
// Address step per beat follows WRITE_ENGINE_BYTE_ADDR_EN (see write_engine_pkg).
module write_engine
    import write_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WRITE_START,
    input  logic [ADDR_WIDTH-1:0] WADDR_START,
    input  logic [31:0]           WRITE_LENGTH,
    output logic                  BUSY,
    output logic                  WREQ_COUNT_DONE,
    output logic                  WACK_COUNT_DONE,
    input  logic                  S_VALID,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  S_READY,
    output logic                  WREQ,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WACK
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(beat_addr_incr(DATA_WIDTH));

    we_state_t             state_q, state_d;
    logic [31:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wreq_q, wreq_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic        start_acc;
    logic        handshake;
    logic        s_ready;
    logic [31:0] req_count;
    logic [31:0] ack_count;
    logic [32:0] accepted;

    assign start_acc = (state_q == IDLE) && WRITE_START;

    // A beat sitting in the WREQ register is accepted but not yet in the request count.
    assign accepted  = {1'b0, req_count} + {32'd0, wreq_q};
    assign s_ready   = (state_q == RUN) && (accepted < {1'b0, len_q});
    assign handshake = S_VALID && s_ready;

    write_beat_counter u_req_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .clr   (start_acc),
        .en    (wreq_q),
        .limit (len_q),
        .count (req_count)
    );

    write_beat_counter u_ack_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .clr   (start_acc),
        .en    (WACK && (state_q != IDLE)),
        .limit (len_q),
        .count (ack_count)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wreq_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (WRITE_START) begin
                    len_d  = WRITE_LENGTH;
                    addr_d = WADDR_START;
                    if (WRITE_LENGTH != 32'd0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (handshake && ((accepted + 33'd1) == {1'b0, len_q})) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ack_count == len_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (handshake) begin
            wreq_d  = 1'b1;
            waddr_d = addr_q;
            wdata_d = S_DATA;
            addr_d  = addr_q + ADDR_STEP;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wreq_q  <= wreq_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign BUSY            = (state_q != IDLE);
    assign S_READY         = s_ready;
    assign WREQ            = wreq_q;
    assign WADDR           = waddr_q;
    assign WDATA           = wdata_q;
    assign WREQ_COUNT_DONE = (req_count == len_q);
    assign WACK_COUNT_DONE = (ack_count == len_q);

endmodule

// File: tb/tb_write_engine.sv
// Scoreboard bench for write_engine: expected writes are queued at each handshake and checked as WREQs appear.
module tb_write_engine;

`ifdef WRITE_ENGINE_BYTE_ADDR_EN
    localparam logic [31:0] INCR = 32'd8;
`else
    localparam logic [31:0] INCR = 32'd1;
`endif

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        WRITE_START = 1'b0;
    logic [31:0] WADDR_START = '0;
    logic [31:0] WRITE_LENGTH = '0;
    logic        BUSY, WREQ_COUNT_DONE, WACK_COUNT_DONE;
    logic        S_VALID = 1'b0;
    logic [63:0] S_DATA = '0;
    logic        S_READY;
    logic        WREQ;
    logic [31:0] WADDR;
    logic [63:0] WDATA;
    logic        WACK = 1'b0;

    write_engine #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .CLK             (CLK),
        .RSTN            (RSTN),
        .WRITE_START     (WRITE_START),
        .WADDR_START     (WADDR_START),
        .WRITE_LENGTH    (WRITE_LENGTH),
        .BUSY            (BUSY),
        .WREQ_COUNT_DONE (WREQ_COUNT_DONE),
        .WACK_COUNT_DONE (WACK_COUNT_DONE),
        .S_VALID         (S_VALID),
        .S_DATA          (S_DATA),
        .S_READY         (S_READY),
        .WREQ            (WREQ),
        .WADDR           (WADDR),
        .WDATA           (WDATA),
        .WACK            (WACK)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_addr;
    logic [31:0] cur_len = '0;
    int          pushed, wreq_seen, acks_done;
    int          first_cyc, last_cyc;
    logic [1:0]  ack_pipe = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, check outputs, then drive inputs for the next edge.
    task automatic step(input bit valid_in, input bit restart);
        exp_t e;
        @(negedge CLK);
        if (WACK) acks_done++;
        check_eq("wreq_done", WREQ_COUNT_DONE, (wreq_seen == int'(cur_len)));
        check_eq("wack_done", WACK_COUNT_DONE, (acks_done >= int'(cur_len)));
        if (WREQ) begin
            if (sb.size() == 0) begin
                check_eq("wreq_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("waddr", WADDR, e.addr);
                check_eq("wdata", WDATA, e.data);
                check_eq("wreq_latency", cyc, e.cyc + 1);
            end
            if (wreq_seen == 0) first_cyc = cyc;
            last_cyc = cyc;
            wreq_seen++;
        end
        WACK     = ack_pipe[1];
        ack_pipe = {ack_pipe[0], WREQ};
        WRITE_START = restart;
        if (restart) begin
            WADDR_START  = 32'h500;
            WRITE_LENGTH = 32'd9;
        end
        S_VALID = valid_in;
        S_DATA  = {$urandom, $urandom};
        if (valid_in && S_READY) begin
            e.addr = exp_addr;
            e.data = S_DATA;
            e.cyc  = cyc;
            sb.push_back(e);
            exp_addr = exp_addr + INCR;
            pushed++;
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] len);
        @(negedge CLK);
        WRITE_START  = 1'b1;
        WADDR_START  = a;
        WRITE_LENGTH = len;
        exp_addr  = a;
        cur_len   = len;
        pushed    = 0;
        wreq_seen = 0;
        acks_done = 0;
        first_cyc = 0;
        last_cyc  = 0;
    endtask

    task automatic burst(input logic [31:0] a, input logic [31:0] len, input bit toggle);
        bit done = 0;
        start_cmd(a, len);
        step(1'b1, 1'b0);
        check_eq("busy_start", BUSY, (len != 0));
        check_eq("sready_start", S_READY, (len != 0));
        for (int k = 1; k < 200; k++) begin
            if (pushed == int'(len) && sb.size() == 0 && ack_pipe == 2'b00 && !WACK && !BUSY) begin
                done = 1;
                break;
            end
            step(toggle ? (k % 2 == 0) : 1'b1, 1'b0);
        end
        if (!done) check_eq("burst_timeout", 0, 1);
        check_eq("wreq_total", wreq_seen, len);
        check_eq("wreq_done_end", WREQ_COUNT_DONE, 1);
        check_eq("wack_done_end", WACK_COUNT_DONE, 1);
        check_eq("busy_end", BUSY, 0);
        if (!toggle && len > 1) check_eq("wreq_b2b", last_cyc - first_cyc, len - 1);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_sready", S_READY, 0);
        check_eq("rst_wreq", WREQ, 0);
        check_eq("rst_waddr", WADDR, 0);
        check_eq("rst_wdata", WDATA, 0);
        check_eq("rst_wreq_done", WREQ_COUNT_DONE, 1);
        check_eq("rst_wack_done", WACK_COUNT_DONE, 1);
        RSTN = 1'b1;

        burst(32'h100, 32'd4, 1'b0);
        burst(32'h40, 32'd3, 1'b1);
        burst(32'hFFFF_FFFE, 32'd3, 1'b0);
        burst(32'h3000, 32'd6, 1'b1);

        // zero length: nothing issued, flags stay high
        burst(32'h700, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            check_eq("len0_sready", S_READY, 0);
            check_eq("len0_busy", BUSY, 0);
        end
        check_eq("len0_wreq", wreq_seen, 0);

        // reset mid-burst, with a restart attempt while running
        start_cmd(32'h200, 32'd5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int k = 0; k < 20 && wreq_seen < 2; k++) step(1'b1, 1'b0);
        check_eq("rst_mid_wreqs", wreq_seen, 2);
        @(negedge CLK);
        RSTN = 1'b0;
        S_VALID = 1'b0;
        WRITE_START = 1'b0;
        WACK = 1'b0;
        ack_pipe = '0;
        @(negedge CLK);
        check_eq("mid_busy", BUSY, 0);
        check_eq("mid_sready", S_READY, 0);
        check_eq("mid_wreq", WREQ, 0);
        check_eq("mid_waddr", WADDR, 0);
        check_eq("mid_wdata", WDATA, 0);
        check_eq("mid_wreq_done", WREQ_COUNT_DONE, 1);
        check_eq("mid_wack_done", WACK_COUNT_DONE, 1);
        RSTN = 1'b1;
        sb.delete();
        cur_len = '0;
        wreq_seen = 0;
        acks_done = 0;
        ack_pipe = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0);
            check_eq("post_rst_sready", S_READY, 0);
        end
        check_eq("post_rst_wreq", wreq_seen, 0);

        burst(32'h800, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
